// File: rtl/interp_block_sequencer_if.sv
// Handshake and strobe bundle between the interpolation block sequencer
// (slave side) and its environment: block fetch upstream, input shift
// register, filter pipeline and output filler downstream (master side).
interface interp_block_sequencer_if;
  logic       start;
  logic       abort;
  logic       row_valid;
  logic       row_ready;
  logic       in_load_L;
  logic       filt_valid;
  logic [2:0] filt_pass;
  logic [2:0] filt_row;
  logic       out_load_L;
  logic [7:0] out_sel;
  logic       busy;
  logic       done;

  modport slave (
    input  start, abort, row_valid,
    output row_ready, in_load_L, filt_valid, filt_pass, filt_row,
           out_load_L, out_sel, busy, done
  );

  modport master (
    output start, abort, row_valid,
    input  row_ready, in_load_L, filt_valid, filt_pass, filt_row,
           out_load_L, out_sel, busy, done
  );
endinterface

// File: rtl/interp_block_sequencer.sv
// Control FSM for one 8x8 sub-pixel interpolation block: loads the
// reference window, issues every pass/row to the filter pipeline, counts
// the filter results into the output filler and pulses done at the end.
module interp_block_sequencer #(
  parameter int ROWS_IN  = 15,
  parameter int ROWS_OUT = 8,
  parameter int PASSES   = 5,
  parameter int FILT_LAT = 3
) (
  input logic                      clock,
  input logic                      reset,
  interp_block_sequencer_if.slave  bus
);

  localparam int TOTAL = PASSES * ROWS_OUT;

  typedef enum logic [2:0] {IDLE, FILL, SETTLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state_q;
  logic [3:0]          row_cnt_q;
  logic [2:0]          pass_q;
  logic [2:0]          row_q;
  logic [5:0]          out_sel_q;
  logic [FILT_LAT-1:0] vld_q;       // filt_valid delayed 1..FILT_LAT cycles
  logic                row_ready_q;
  logic                filt_valid_q;
  logic                busy_q;
  logic                done_q;

  logic accept;
  logic cap;

  assign accept = bus.row_valid & row_ready_q;
  // The oldest tap of the valid line marks a filter result on the bus now.
  assign cap    = vld_q[FILT_LAT-1];

  // Sequencer FSM with registered strobes, counters and valid delay line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      row_cnt_q    <= '0;
      pass_q       <= '0;
      row_q        <= '0;
      out_sel_q    <= '0;
      vld_q        <= '0;
      row_ready_q  <= 1'b0;
      filt_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Capture path runs regardless of state so it overlaps ISSUE.
      vld_q  <= (vld_q << 1) | FILT_LAT'(filt_valid_q);
      if (cap) out_sel_q <= out_sel_q + 6'd1;

      if (bus.abort) begin
        // Abort outranks every transition, including start in IDLE.
        state_q      <= IDLE;
        row_cnt_q    <= '0;
        pass_q       <= '0;
        row_q        <= '0;
        out_sel_q    <= '0;
        vld_q        <= '0;
        row_ready_q  <= 1'b0;
        filt_valid_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (bus.start) begin
            state_q     <= FILL;
            row_cnt_q   <= '0;
            pass_q      <= '0;
            row_q       <= '0;
            out_sel_q   <= '0;
            vld_q       <= '0;
            row_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
          FILL: if (accept) begin
            row_cnt_q <= row_cnt_q + 4'd1;
            if (row_cnt_q == 4'(ROWS_IN - 1)) begin
              state_q     <= SETTLE;
              row_ready_q <= 1'b0;
            end
          end
          // One quiet cycle so the negedge shift register shows the window.
          SETTLE: begin
            state_q      <= ISSUE;
            filt_valid_q <= 1'b1;
            pass_q       <= '0;
            row_q        <= '0;
          end
          ISSUE: begin
            if (row_q == 3'(ROWS_OUT - 1)) begin
              row_q <= '0;
              if (pass_q == 3'(PASSES - 1)) begin
                state_q      <= DRAIN;
                filt_valid_q <= 1'b0;
                pass_q       <= '0;
              end else begin
                pass_q <= pass_q + 3'd1;
              end
            end else begin
              row_q <= row_q + 3'd1;
            end
          end
          // Leave once the final result is being captured this cycle.
          DRAIN: if (cap && out_sel_q == 6'(TOTAL - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
          DONE: begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            out_sel_q <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.row_ready  = row_ready_q;
  assign bus.in_load_L  = ~accept;
  assign bus.filt_valid = filt_valid_q;
  assign bus.filt_pass  = pass_q;
  assign bus.filt_row   = row_q;
  assign bus.out_load_L = ~cap;
  assign bus.out_sel    = {2'b00, out_sel_q};
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_interp_block_sequencer.sv
// Randomised bench for interp_block_sequencer. The reference model is a
// timeline: once the cycle f of the last accepted row is known, every
// later strobe follows from f by plain arithmetic.
module tb_interp_block_sequencer;

  localparam int ROWS_IN  = 15;
  localparam int ROWS_OUT = 8;
  localparam int PASSES   = 5;
  localparam int L        = 3;
  localparam int TOTAL    = PASSES * ROWS_OUT;
  localparam int SENT     = 1000000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  interp_block_sequencer_if bus();

  interp_block_sequencer #(
    .ROWS_IN(ROWS_IN), .ROWS_OUT(ROWS_OUT), .PASSES(PASSES), .FILT_LAT(L)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string pfx);
    chk({pfx, "_busy"}, int'(bus.busy), 0);
    chk({pfx, "_row_ready"}, int'(bus.row_ready), 0);
    chk({pfx, "_filt_valid"}, int'(bus.filt_valid), 0);
    chk({pfx, "_out_load_L"}, int'(bus.out_load_L), 1);
    chk({pfx, "_done"}, int'(bus.done), 0);
  endtask

  // rv_mode: 0 always valid, 1 toggling 1/0, 2 random.
  // abort_k: issue index carrying abort (-1 none).
  // rst_off: cycle f+rst_off gets an async reset mid-cycle (-1 none).
  task automatic run_block(input int rv_mode, input int abort_k,
                           input int rst_off, input bit hold);
    int  f, acc, ab_c, k_iss, k_cap, t_done;
    bit  rv, e_rr, aborted, ended;
    f = SENT; acc = 0; ended = 0;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = hold;
    for (int c = 1; c < 600; c++) begin
      case (rv_mode)
        0:       rv = 1'b1;
        1:       rv = c[0];
        default: rv = ($urandom_range(0, 9) < 7);
      endcase
      ab_c = (abort_k >= 0 && f < SENT) ? f + 2 + abort_k : -1;
      bus.row_valid = rv;
      bus.abort     = (ab_c >= 0 && c == ab_c);
      @(negedge clock);
      aborted = (ab_c >= 0 && c > ab_c);
      k_iss   = c - (f + 2);
      k_cap   = c - (f + 2 + L);
      t_done  = f + 2 + L + TOTAL;
      e_rr    = !aborted && c <= f;
      if (aborted) begin
        chk_idle("abort");
      end else begin
        chk("row_ready", int'(bus.row_ready), int'(e_rr));
        chk("filt_valid", int'(bus.filt_valid), int'(k_iss >= 0 && k_iss < TOTAL));
        if (k_iss >= 0 && k_iss < TOTAL) begin
          chk("filt_pass", int'(bus.filt_pass), k_iss / ROWS_OUT);
          chk("filt_row", int'(bus.filt_row), k_iss % ROWS_OUT);
        end
        chk("out_load_L", int'(bus.out_load_L), int'(!(k_cap >= 0 && k_cap < TOTAL)));
        if (k_cap >= 0 && k_cap < TOTAL) chk("out_sel", int'(bus.out_sel), k_cap);
        chk("busy", int'(bus.busy), int'(c <= t_done));
        chk("done", int'(bus.done), int'(c == t_done));
      end
      chk("in_load_L", int'(bus.in_load_L), int'(!(rv && e_rr)));
      if (e_rr && rv) begin
        acc++;
        if (acc == ROWS_IN) f = c;
      end
      if (aborted && c == ab_c + 3) begin ended = 1; break; end
      if (!aborted && c == t_done + 1) begin ended = 1; break; end
      if (rst_off >= 0 && f < SENT && c == f + rst_off) begin
        #1 reset = 1'b1;
        #1;
        chk_idle("rst");
        chk("rst_out_sel", int'(bus.out_sel), 0);
        chk("rst_in_load_L", int'(bus.in_load_L), 1);
        @(posedge clock); #1;
        reset = 1'b0;
        ended = 1;
        break;
      end
      @(posedge clock); #1;
    end
    bus.abort = 1'b0;
    if (!ended) chk("block_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.row_valid = 1'b0;
    #12;
    @(negedge clock);
    chk_idle("reset");
    chk("reset_out_sel", int'(bus.out_sel), 0);
    chk("reset_in_load_L", int'(bus.in_load_L), 1);
    chk("reset_pass_row", int'({bus.filt_pass, bus.filt_row}), 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // start and abort together in IDLE: abort wins
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clock);
    chk_idle("start_abort");
    @(posedge clock); #1;

    run_block(0, -1, -1, 1'b0);      // continuous rows
    run_block(1, -1, -1, 1'b0);      // toggling rows, 29-cycle FILL
    run_block(0, 9, -1, 1'b0);       // abort on 10th issue
    run_block(2, -1, -1, 1'b0);      // clean block after abort
    run_block(2, -1, 43, 1'b0);      // reset mid-DRAIN
    run_block(0, -1, -1, 1'b0);      // clean block after reset
    run_block(0, -1, -1, 1'b1);      // start held through the block
    run_block(2, -1, -1, 1'b0);      // back-to-back second block
    for (int i = 0; i < 3; i++) run_block(2, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
